// File: rtl/vga_fb_scan.sv
// Parametrised VGA scan engine and linear framebuffer reader with integer pixel scaling.
// Optional colour-bar generator when VGA_TESTPAT_EN is defined (adds the test_mode input).
module vga_fb_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int SCALE_SH = 0,
  parameter int MEM_LAT  = 2,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 19,
  parameter int FB_BASE  = 0
) (
  input  logic              clk,
  input  logic              rstn,
`ifdef VGA_TESTPAT_EN
  input  logic              test_mode,
`endif
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE >> SCALE_SH);
  localparam logic [2:0] SUB_MAX = 3'((1 << SCALE_SH) - 1);

  generate
    if (SCALE_SH < 0 || SCALE_SH > 3 ||
        (H_ACTIVE % (1 << SCALE_SH)) != 0 || (V_ACTIVE % (1 << SCALE_SH)) != 0) begin : g_bad_scale
      $error("vga_fb_scan: SCALE_SH out of range or active area not divisible by 2**SCALE_SH");
    end
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
      $error("vga_fb_scan: MEM_LAT must be within 1..8");
    end
    if (DATA_W < 12) begin : g_bad_width
      $error("vga_fb_scan: DATA_W must be at least 12");
    end else if (DATA_W > 12) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^mem_data[DATA_W-1:12];
    end
  endgenerate

  typedef struct packed {
`ifdef VGA_TESTPAT_EN
    logic       tp;
    logic [2:0] bar;
`endif
    logic       fs;
    logic       de;
    logic       vs;
    logic       hs;
  } pix_t;

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] xoff;
  logic [2:0]        xsub;
  logic [2:0]        ysub;
  logic              h_wrap;
  logic              v_wrap;
  pix_t              req;
  logic              req_en;
  logic [11:0]       pix_rgb;
  pix_t              pipe [MEM_LAT+1];

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // Address is built incrementally: xoff steps every 2**SCALE_SH pixels, line_base every 2**SCALE_SH lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_base <= BASE;
      xoff      <= '0;
      xsub      <= '0;
      ysub      <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      xoff <= '0;
      xsub <= '0;
      if (v_wrap) begin
        vcnt      <= '0;
        line_base <= BASE;
        ysub      <= '0;
      end else begin
        vcnt <= vcnt + 1'b1;
        if (ysub == SUB_MAX) begin
          ysub      <= '0;
          line_base <= line_base + STRIDE;
        end else begin
          ysub <= ysub + 1'b1;
        end
      end
    end else begin
      hcnt <= hcnt + 1'b1;
      if (xsub == SUB_MAX) begin
        xsub <= '0;
        xoff <= xoff + 1'b1;
      end else begin
        xsub <= xsub + 1'b1;
      end
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
  logic          test_mode_q;
  logic          tp_act;
  logic [2:0]    bar_idx;
  logic [HW-1:0] bar_sub;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 12'hFFF;
      3'd1:    bar_colour = 12'hFF0;
      3'd2:    bar_colour = 12'h0FF;
      3'd3:    bar_colour = 12'h0F0;
      3'd4:    bar_colour = 12'hF0F;
      3'd5:    bar_colour = 12'hF00;
      3'd6:    bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  // Mode only changes on the last counter position so a whole frame is either pattern or framebuffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      test_mode_q <= 1'b0;
      tp_act      <= 1'b0;
      bar_idx     <= '0;
      bar_sub     <= '0;
    end else begin
      test_mode_q <= test_mode;
      if (h_wrap && v_wrap) tp_act <= test_mode_q;
      if (h_wrap) begin
        bar_idx <= '0;
        bar_sub <= '0;
      end else if (bar_sub == BAR_LAST) begin
        bar_sub <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_sub <= bar_sub + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    req    = '0;
    req.de = (hcnt < H_ACT) && (vcnt < V_ACT);
    req.hs = (hcnt >= HS_BEG) && (hcnt < HS_END);
    req.vs = (vcnt >= VS_BEG) && (vcnt < VS_END);
    req.fs = (hcnt == '0) && (vcnt == '0);
    req_en = req.de;
`ifdef VGA_TESTPAT_EN
    req.tp  = tp_act;
    req.bar = bar_idx;
    req_en  = req.de && !tp_act;
`endif
  end

  // mem_data is captured MEM_LAT edges after the edge that launched the request, i.e. into rgb.
  always_comb begin
    pix_rgb = mem_data[11:0];
`ifdef VGA_TESTPAT_EN
    if (pipe[MEM_LAT-1].tp) pix_rgb = bar_colour(pipe[MEM_LAT-1].bar);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= MEM_LAT; i++) pipe[i] <= '0;
      mem_en   <= 1'b0;
      mem_addr <= BASE;
      rgb      <= '0;
    end else begin
      pipe[0] <= req;
      for (int i = 1; i <= MEM_LAT; i++) pipe[i] <= pipe[i-1];
      mem_en   <= req_en;
      mem_addr <= line_base + xoff;
      rgb      <= pipe[MEM_LAT-1].de ? pix_rgb : 12'h000;
    end
  end

  assign de          = pipe[MEM_LAT].de;
  assign hs          = pipe[MEM_LAT].hs ^ ~SYNC_POL;
  assign vs          = pipe[MEM_LAT].vs ^ ~SYNC_POL;
  assign frame_start = pipe[MEM_LAT].fs;

endmodule

// File: tb/tb_vga_fb_scan.sv
// Bench for vga_fb_scan: small 24x12 geometry (16x8 active), default-style instance A and a
// scaled/offset/latency-4/active-high instance B with its own reset for mid-line reset checks.
module tb_vga_fb_scan;

  logic        clk = 1'b0;
  logic        rstn_a, rstn_b;
  logic [15:0] mem_data_a, mem_data_b;
  logic        mem_en_a, mem_en_b;
  logic [18:0] mem_addr_a, mem_addr_b;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [11:0] rgb_a, rgb_b;
`ifdef VGA_TESTPAT_EN
  logic        test_mode_a = 1'b0;
  logic        test_mode_b = 1'b0;
`endif
  logic [18:0] qa, qb1, qb2, qb3;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_fb_scan #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .SCALE_SH(0), .MEM_LAT(2), .DATA_W(16), .ADDR_W(19), .FB_BASE(0)
  ) dut_a (
    .clk(clk), .rstn(rstn_a),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode_a),
`endif
    .mem_data(mem_data_a), .mem_en(mem_en_a), .mem_addr(mem_addr_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_fb_scan #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .SCALE_SH(1), .MEM_LAT(4), .DATA_W(16), .ADDR_W(19), .FB_BASE(1000)
  ) dut_b (
    .clk(clk), .rstn(rstn_b),
`ifdef VGA_TESTPAT_EN
    .test_mode(test_mode_b),
`endif
    .mem_data(mem_data_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  // Memories return addr[11:0]; data is sampled MEM_LAT edges after the launching edge.
  always @(posedge clk) begin
    qa  <= mem_addr_a;
    qb1 <= mem_addr_b;
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign mem_data_a = {4'h0, qa[11:0]};
  assign mem_data_b = {4'h0, qb3[11:0]};

  function automatic logic [11:0] bar_rgb(input int idx);
    case (idx)
      0: bar_rgb = 12'hFFF;
      1: bar_rgb = 12'hFF0;
      2: bar_rgb = 12'h0FF;
      3: bar_rgb = 12'h0F0;
      4: bar_rgb = 12'hF0F;
      5: bar_rgb = 12'hF00;
      6: bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  endfunction

  task automatic test_reset();
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_en_a, mem_addr_a, de_a, hs_a, vs_a, fs_a, rgb_a} !== {1'b0, 19'd0, 4'b0110, 12'h0}) begin
      bad++;
      $display("FAIL reset_a got en=%b addr=%0d de=%b hs=%b vs=%b fs=%b rgb=%h want 0,0,0,1,1,0,000",
               mem_en_a, mem_addr_a, de_a, hs_a, vs_a, fs_a, rgb_a);
    end
    total++;
    if ({mem_en_b, mem_addr_b, de_b, hs_b, vs_b, fs_b, rgb_b} !== {1'b0, 19'd1000, 4'b0000, 12'h0}) begin
      bad++;
      $display("FAIL reset_b got en=%b addr=%0d de=%b hs=%b vs=%b fs=%b rgb=%h want 0,1000,0,0,0,0,000",
               mem_en_b, mem_addr_b, de_b, hs_b, vs_b, fs_b, rgb_b);
    end
  endtask

  task automatic test_frame_a();
    int hc, vc, d, ox, oy, blank_en, fs_n;
    logic en, act;
    logic [15:0] exp_o;
    blank_en = 0;
    fs_n = 0;
    rstn_a = 1'b1;
    for (int c = 0; c <= 300; c++) begin
      @(negedge clk);
      hc = c % 24;
      vc = (c / 24) % 12;
      en = (hc < 16) && (vc < 8);
      total++;
      if (mem_en_a !== en) begin
        bad++;
        $display("FAIL a_mem_en c=%0d got=%b want=%b", c, mem_en_a, en);
      end
      if (en) begin
        total++;
        if (mem_addr_a !== 19'(vc * 16 + hc)) begin
          bad++;
          $display("FAIL a_mem_addr c=%0d got=%0d want=%0d", c, mem_addr_a, vc * 16 + hc);
        end
      end
      if (c >= 184 && c <= 287 && mem_en_a === 1'b1) blank_en++;
      if (fs_a === 1'b1) fs_n++;
      d = c - 2;
      if (d < 0) begin
        exp_o = {4'b0110, 12'h0};
      end else begin
        ox = d % 24;
        oy = (d / 24) % 12;
        act = (ox < 16) && (oy < 8);
        exp_o = {act, !(ox >= 18 && ox < 21), !(oy >= 9 && oy < 11), (ox == 0 && oy == 0),
                 act ? 12'(oy * 16 + ox) : 12'h0};
      end
      total++;
      if ({de_a, hs_a, vs_a, fs_a, rgb_a} !== exp_o) begin
        bad++;
        $display("FAIL a_out c=%0d got de/hs/vs/fs/rgb=%h want=%h", c, {de_a, hs_a, vs_a, fs_a, rgb_a}, exp_o);
      end
      if (c == 2) begin
        total++;
        if ({de_a, fs_a, rgb_a} !== {2'b11, 12'h000}) begin
          bad++;
          $display("FAIL a_first_pixel got de=%b fs=%b rgb=%h want 1 1 000", de_a, fs_a, rgb_a);
        end
      end
      if (c == 17) begin
        total++;
        if (rgb_a !== 12'h00F) begin
          bad++;
          $display("FAIL a_last_x got=%h want=00F", rgb_a);
        end
      end
      if (c == 183) begin
        total++;
        if (mem_addr_a !== 19'd127) begin
          bad++;
          $display("FAIL a_last_addr got=%0d want=127", mem_addr_a);
        end
      end
      if (c == 288) begin
        total++;
        if ({mem_en_a, mem_addr_a} !== {1'b1, 19'd0}) begin
          bad++;
          $display("FAIL a_wrap_addr got en=%b addr=%0d want en=1 addr=0", mem_en_a, mem_addr_a);
        end
      end
    end
    total++;
    if (blank_en != 0) begin
      bad++;
      $display("FAIL a_blank_en got=%0d enables want=0", blank_en);
    end
    total++;
    if (fs_n != 2) begin
      bad++;
      $display("FAIL a_frame_start_count got=%0d want=2", fs_n);
    end
  endtask

  task automatic test_scale_reset_b();
    int hc, vc, d, ox, oy, lim;
    logic en, act;
    logic [15:0] exp_o;
    for (int ph = 0; ph < 2; ph++) begin
      rstn_b = 1'b1;
      lim = (ph == 0) ? 370 : 40;
      for (int c = 0; c <= lim; c++) begin
        @(negedge clk);
        hc = c % 24;
        vc = (c / 24) % 12;
        en = (hc < 16) && (vc < 8);
        total++;
        if (mem_en_b !== en) begin
          bad++;
          $display("FAIL b_mem_en ph=%0d c=%0d got=%b want=%b", ph, c, mem_en_b, en);
        end
        if (en) begin
          total++;
          if (mem_addr_b !== 19'(1000 + (vc / 2) * 8 + hc / 2)) begin
            bad++;
            $display("FAIL b_mem_addr ph=%0d c=%0d got=%0d want=%0d", ph, c, mem_addr_b,
                     1000 + (vc / 2) * 8 + hc / 2);
          end
        end
        d = c - 4;
        if (d < 0) begin
          exp_o = 16'h0;
        end else begin
          ox = d % 24;
          oy = (d / 24) % 12;
          act = (ox < 16) && (oy < 8);
          exp_o = {act, (ox >= 18 && ox < 21), (oy >= 9 && oy < 11), (ox == 0 && oy == 0),
                   act ? 12'(1000 + (oy / 2) * 8 + ox / 2) : 12'h0};
        end
        total++;
        if ({de_b, hs_b, vs_b, fs_b, rgb_b} !== exp_o) begin
          bad++;
          $display("FAIL b_out ph=%0d c=%0d got de/hs/vs/fs/rgb=%h want=%h", ph, c,
                   {de_b, hs_b, vs_b, fs_b, rgb_b}, exp_o);
        end
        if (ph == 0 && c == 4) begin
          total++;
          if ({de_b, rgb_b} !== {1'b1, 12'h3E8}) begin
            bad++;
            $display("FAIL b_first_pixel got de=%b rgb=%h want 1 3E8", de_b, rgb_b);
          end
        end
        if (ph == 0 && (c == 1 || c == 2 || c == 48 || c == 183)) begin
          total++;
          if (mem_addr_b !== ((c == 1) ? 19'd1000 : (c == 2) ? 19'd1001 : (c == 48) ? 19'd1008 : 19'd1031)) begin
            bad++;
            $display("FAIL b_scaled_addr c=%0d got=%0d", c, mem_addr_b);
          end
        end
      end
      if (ph == 0) begin
        rstn_b = 1'b0;
        #1;
        total++;
        if ({mem_en_b, mem_addr_b, de_b, hs_b, vs_b, fs_b, rgb_b} !== {1'b0, 19'd1000, 4'b0000, 12'h0}) begin
          bad++;
          $display("FAIL b_async_reset got en=%b addr=%0d de=%b hs=%b vs=%b fs=%b rgb=%h want 0,1000,0,0,0,0,000",
                   mem_en_b, mem_addr_b, de_b, hs_b, vs_b, fs_b, rgb_b);
        end
        @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

`ifdef VGA_TESTPAT_EN
  task automatic test_testpat();
    int hc, vc, d, ox, oy;
    logic en, act;
    logic [15:0] exp_o;
    rstn_a = 1'b0;
    @(negedge clk);
    rstn_a = 1'b1;
    for (int c = 0; c <= 320; c++) begin
      @(negedge clk);
      hc = c % 24;
      vc = (c / 24) % 12;
      en = (hc < 16) && (vc < 8) && (c < 288);
      total++;
      if (mem_en_a !== en) begin
        bad++;
        $display("FAIL tp_mem_en c=%0d got=%b want=%b", c, mem_en_a, en);
      end
      d = c - 2;
      if (d < 0) begin
        exp_o = {4'b0110, 12'h0};
      end else begin
        ox = d % 24;
        oy = (d / 24) % 12;
        act = (ox < 16) && (oy < 8);
        exp_o = {act, !(ox >= 18 && ox < 21), !(oy >= 9 && oy < 11), (ox == 0 && oy == 0),
                 !act ? 12'h0 : (d >= 288) ? bar_rgb(ox / 2) : 12'(oy * 16 + ox)};
      end
      total++;
      if ({de_a, hs_a, vs_a, fs_a, rgb_a} !== exp_o) begin
        bad++;
        $display("FAIL tp_out c=%0d got de/hs/vs/fs/rgb=%h want=%h", c, {de_a, hs_a, vs_a, fs_a, rgb_a}, exp_o);
      end
      if (c == 290 || c == 292 || c == 305) begin
        total++;
        if (rgb_a !== ((c == 290) ? 12'hFFF : (c == 292) ? 12'hFF0 : 12'h000)) begin
          bad++;
          $display("FAIL tp_bar c=%0d got=%h", c, rgb_a);
        end
      end
      if (c == 100) test_mode_a = 1'b1;
    end
    test_mode_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_a();
    test_scale_reset_b();
`ifdef VGA_TESTPAT_EN
    test_testpat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
